packet_receiver: RTL
====================

PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 Parameter PAYLOAD_BYTES, default 1024, number of payload bytes per frame.
REQ-002 Parameter ETHERTYPE, default 16'h88B5, required type/length field value.
REQ-003 clk  in  1  single clock, rx_data/rx_ctl sampled on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 rx_data  in  8  received byte.
REQ-006 rx_ctl  in  2  line control: 2'b11 data valid, 2'b00 idle, other values mean line error.
REQ-007 rx_enable  in  1  receiver enable, sampled only in IDLE.
REQ-008 mac_addr  in  48  own station address.
REQ-009 payload_data  out  8  payload byte.
REQ-010 payload_valid  out  1  payload_data/payload_addr valid this cycle.
REQ-011 payload_addr  out  10  payload byte index, 0..PAYLOAD_BYTES-1.
REQ-012 frame_ticks  out  64  ticks field of the last completed frame, big-endian.
REQ-013 frame_src  out  48  source address of the last completed frame.
REQ-014 frame_done  out  1  one-cycle pulse at end of a fully received frame.
REQ-015 frame_ok  out  1  FCS match, qualified by frame_done.
REQ-016 good_count, crc_err_count, drop_count  out  16 each  event counters, wrap at 16'hFFFF to 0.

Function
REQ-017 States: IDLE, PREAMBLE, DEST, SRC, TYPE, TICKS, PAYLOAD, FCS, CHECK, DISCARD; 11-bit byte counter indexes fields.
REQ-018 IDLE -> PREAMBLE on rx_ctl==11 && rx_data==8'h55 && rx_enable; otherwise remain in IDLE.
REQ-019 PREAMBLE: each further 8'h55 stays; 8'hD5 -> DEST; any other byte -> DISCARD; more than 7 bytes of 8'h55 -> DISCARD.
REQ-020 DEST: 6 bytes; accept when all are 8'hFF or equal to mac_addr (MSB first); else DISCARD after 6th byte.
REQ-021 SRC: 6 bytes into shadow register; TYPE: 2 bytes, mismatch with ETHERTYPE -> DISCARD.
REQ-022 TICKS: 8 bytes, first byte -> bits [63:56], into shadow register.
REQ-023 PAYLOAD: each byte drives payload_valid=1 with payload_data=byte and payload_addr=index on the next cycle (1-cycle latency); after PAYLOAD_BYTES bytes -> FCS.
REQ-024 CRC-32 covers DEST first byte through last payload byte; the 4 FCS bytes are compared MSB first against the engine output captured at the end of payload.
REQ-025 After the 4th FCS byte -> CHECK: frame_done=1 for one cycle, frame_ok=match; frame_ticks/frame_src updated from shadows only on match; good_count or crc_err_count increments.
REQ-026 CHECK -> IDLE if rx_ctl==00, else DISCARD (overlong frame: frame_done still issued, drop_count unchanged).
REQ-027 Any state except IDLE/DISCARD/CHECK: rx_ctl==00 or a line error -> DISCARD, drop_count+1, no frame_done.
REQ-028 DEST/TYPE/PREAMBLE rejection also adds 1 to drop_count, exactly once per frame.
REQ-029 DISCARD -> IDLE on first cycle rx_ctl==00; payload_valid stays 0 in DISCARD.
REQ-030 Minimum 1 idle cycle between frames; back-to-back frames separated by one idle cycle are each received.

Reset
REQ-031 reset_n low: state IDLE, counters 0, payload_valid/frame_done/frame_ok 0, payload_data/payload_addr 0, frame_ticks/frame_src 0, CRC engine reset.
REQ-032 Reset mid-frame abandons the frame without counting; reception restarts at the next preamble after release.

Structure
REQ-033 State encoding, ETHERTYPE default, preamble/SFD constants and field lengths live in the shared package with the transmitter's constants.
REQ-034 One sub-module: the existing crc engine (byte-wide CRC-32), held in reset from IDLE and enabled DEST..last payload byte.

Verification
REQ-035 Broadcast frame, ticks 64'h0123456789ABCDEF, payload ramp 0..255 repeated, correct FCS -> 1024 payload_valid beats, frame_ok=1, frame_ticks matches, good_count=1.
REQ-036 Same frame with payload byte 500 inverted -> frame_done with frame_ok=0, crc_err_count=1, frame_ticks unchanged.
REQ-037 Type 16'h0800, or unicast destination not equal to mac_addr -> zero payload_valid, drop_count=1, no frame_done.
REQ-038 rx_ctl forced to 00 at payload byte 300 -> DISCARD, drop_count=1; next valid frame, 1 idle cycle later -> good_count=1.
REQ-039 reset_n pulsed low during TICKS -> all outputs 0 immediately; following good frame -> good_count=1.
REQ-040 rx_enable=0 through a whole frame -> no activity, counters unchanged.

Source files
------------

// File: rtl/packet_receiver_pkg.sv
// Shared framing constants for the packet transmitter/receiver pair.
// Holds the preamble/SFD bytes, field lengths, line-control codes, the default
// ethertype, the receiver state encoding, the frame-info payload struct and
// the byte-wide CRC-32 step function.
package packet_receiver_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [7:0]  BCAST_BYTE    = 8'hFF;

  localparam int unsigned PREAMBLE_MAX  = 7;
  localparam int unsigned ADDR_BYTES    = 6;
  localparam int unsigned TYPE_BYTES    = 2;
  localparam int unsigned TICKS_BYTES   = 8;
  localparam int unsigned FCS_BYTES     = 4;

  localparam int unsigned DEFAULT_PAYLOAD_BYTES = 1024;
  localparam logic [15:0] DEFAULT_ETHERTYPE     = 16'h88B5;

  localparam int unsigned BYTE_CNT_W   = 11;
  localparam int unsigned PAYLOAD_AW   = 10;

  localparam logic [1:0]  CTL_VALID    = 2'b11;
  localparam logic [1:0]  CTL_IDLE     = 2'b00;

  // Reflected CRC-32 (IEEE 802.3) polynomial and preset value
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DEST,
    ST_SRC,
    ST_TYPE,
    ST_TICKS,
    ST_PAYLOAD,
    ST_FCS,
    ST_CHECK,
    ST_DISCARD
  } rx_state_e;

  typedef struct packed {
    logic [63:0] ticks;
    logic [47:0] src;
  } frame_info_t;

  // One byte through the reflected CRC-32 register, LSB of the byte first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/packet_receiver_crc.sv
// Byte-wide CRC-32 engine.
// Ports: clk, reset_n (async active-low), clear (sync preset), enable (absorb
// data this cycle), data (byte in), crc_state (raw register; FCS is its
// bitwise complement).
module packet_receiver_crc
  import packet_receiver_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc_state
);

  // CRC register: clear has priority over enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    crc_state <= CRC_INIT;
    else if (clear)  crc_state <= CRC_INIT;
    else if (enable) crc_state <= crc32_byte(crc_state, data);
  end

endmodule

// File: rtl/packet_receiver.sv
// Frame receiver: preamble/SFD hunt, destination filter, source/type/ticks
// capture, payload streaming with 1-cycle latency, CRC-32 check and event
// counters.
// Ports: clk, reset_n; rx_data/rx_ctl/rx_enable line inputs; mac_addr own
// address; payload_data/payload_valid/payload_addr stream out; frame_ticks/
// frame_src last good frame info; frame_done/frame_ok end-of-frame status;
// good_count/crc_err_count/drop_count wrapping event counters.
module packet_receiver
  import packet_receiver_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = DEFAULT_PAYLOAD_BYTES,
  parameter logic [15:0] ETHERTYPE     = DEFAULT_ETHERTYPE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic [1:0]            rx_ctl,
  input  logic                  rx_enable,
  input  logic [47:0]           mac_addr,
  output logic [7:0]            payload_data,
  output logic                  payload_valid,
  output logic [PAYLOAD_AW-1:0] payload_addr,
  output logic [63:0]           frame_ticks,
  output logic [47:0]           frame_src,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [15:0]           good_count,
  output logic [15:0]           crc_err_count,
  output logic [15:0]           drop_count
);

  localparam logic [BYTE_CNT_W-1:0] PRE_MAX      = BYTE_CNT_W'(PREAMBLE_MAX);
  localparam logic [BYTE_CNT_W-1:0] ADDR_LAST    = BYTE_CNT_W'(ADDR_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] TYPE_LAST    = BYTE_CNT_W'(TYPE_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] TICKS_LAST   = BYTE_CNT_W'(TICKS_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] PAYLOAD_LAST = BYTE_CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] FCS_LAST     = BYTE_CNT_W'(FCS_BYTES - 1);

  rx_state_e               state_q, state_d;
  logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    dest_bc_q, dest_bc_d;
  logic                    dest_uc_q, dest_uc_d;
  logic [7:0]              type_hi_q, type_hi_d;
  logic                    fcs_match_q, fcs_match_d;
  frame_info_t             shadow_q, shadow_d;
  frame_info_t             frame_d;

  logic                    payload_valid_d;
  logic [7:0]              payload_data_d;
  logic [PAYLOAD_AW-1:0]   payload_addr_d;
  logic                    frame_done_d;
  logic                    frame_ok_d;
  logic [15:0]             good_d, crc_err_d, drop_d;

  logic                    crc_clear_c;
  logic                    crc_en_c;
  logic [31:0]             crc_state;
  logic [31:0]             fcs_c;
  logic                    line_valid_c;
  logic                    line_idle_c;
  logic                    abort_c;
  logic [7:0]              mac_byte_c;
  logic [7:0]              fcs_byte_c;
  logic                    bc_hit_c;
  logic                    uc_hit_c;
  logic                    fcs_hit_c;

  packet_receiver_crc u_crc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (crc_clear_c),
    .enable    (crc_en_c),
    .data      (rx_data),
    .crc_state (crc_state)
  );

  assign fcs_c        = ~crc_state;
  assign line_valid_c = (rx_ctl == CTL_VALID);
  assign line_idle_c  = (rx_ctl == CTL_IDLE);

  // Own-address byte for the current DEST position, MSB first
  always_comb begin
    mac_byte_c = mac_addr[7:0];
    case (cnt_q[2:0])
      3'd0:    mac_byte_c = mac_addr[47:40];
      3'd1:    mac_byte_c = mac_addr[39:32];
      3'd2:    mac_byte_c = mac_addr[31:24];
      3'd3:    mac_byte_c = mac_addr[23:16];
      3'd4:    mac_byte_c = mac_addr[15:8];
      default: mac_byte_c = mac_addr[7:0];
    endcase
  end

  // Expected FCS byte for the current FCS position, MSB first
  always_comb begin
    fcs_byte_c = fcs_c[7:0];
    case (cnt_q[1:0])
      2'd0:    fcs_byte_c = fcs_c[31:24];
      2'd1:    fcs_byte_c = fcs_c[23:16];
      2'd2:    fcs_byte_c = fcs_c[15:8];
      default: fcs_byte_c = fcs_c[7:0];
    endcase
  end

  assign bc_hit_c  = dest_bc_q   && (rx_data == BCAST_BYTE);
  assign uc_hit_c  = dest_uc_q   && (rx_data == mac_byte_c);
  assign fcs_hit_c = fcs_match_q && (rx_data == fcs_byte_c);

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    dest_bc_d       = dest_bc_q;
    dest_uc_d       = dest_uc_q;
    type_hi_d       = type_hi_q;
    fcs_match_d     = fcs_match_q;
    shadow_d        = shadow_q;
    frame_d.ticks   = frame_ticks;
    frame_d.src     = frame_src;
    payload_valid_d = 1'b0;
    payload_data_d  = payload_data;
    payload_addr_d  = payload_addr;
    frame_done_d    = 1'b0;
    frame_ok_d      = 1'b0;
    good_d          = good_count;
    crc_err_d       = crc_err_count;
    drop_d          = drop_count;
    crc_clear_c     = 1'b0;
    crc_en_c        = 1'b0;
    abort_c         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        crc_clear_c = 1'b1;
        if (line_valid_c && rx_data == PREAMBLE_BYTE && rx_enable) begin
          state_d = ST_PREAMBLE;
          cnt_d   = BYTE_CNT_W'(1);
        end
      end

      ST_PREAMBLE: begin
        crc_clear_c = 1'b1;
        if (!line_valid_c) begin
          abort_c = 1'b1;
        end else if (rx_data == PREAMBLE_BYTE) begin
          if (cnt_q >= PRE_MAX) abort_c = 1'b1;
          else                  cnt_d   = cnt_q + BYTE_CNT_W'(1);
        end else if (rx_data == SFD_BYTE) begin
          state_d   = ST_DEST;
          cnt_d     = '0;
          dest_bc_d = 1'b1;
          dest_uc_d = 1'b1;
        end else begin
          abort_c = 1'b1;
        end
      end

      ST_DEST: begin
        if (!line_valid_c) begin
          abort_c = 1'b1;
        end else begin
          crc_en_c  = 1'b1;
          dest_bc_d = bc_hit_c;
          dest_uc_d = uc_hit_c;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (bc_hit_c || uc_hit_c) state_d = ST_SRC;
            else                      abort_c = 1'b1;
          end else begin
            cnt_d = cnt_q + BYTE_CNT_W'(1);
          end
        end
      end

      ST_SRC: begin
        if (!line_valid_c) begin
          abort_c = 1'b1;
        end else begin
          crc_en_c     = 1'b1;
          shadow_d.src = {shadow_q.src[39:0], rx_data};
          if (cnt_q == ADDR_LAST) begin
            state_d = ST_TYPE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BYTE_CNT_W'(1);
          end
        end
      end

      ST_TYPE: begin
        if (!line_valid_c) begin
          abort_c = 1'b1;
        end else begin
          crc_en_c = 1'b1;
          if (cnt_q == TYPE_LAST) begin
            cnt_d = '0;
            if ({type_hi_q, rx_data} == ETHERTYPE) state_d = ST_TICKS;
            else                                   abort_c = 1'b1;
          end else begin
            type_hi_d = rx_data;
            cnt_d     = cnt_q + BYTE_CNT_W'(1);
          end
        end
      end

      ST_TICKS: begin
        if (!line_valid_c) begin
          abort_c = 1'b1;
        end else begin
          crc_en_c       = 1'b1;
          shadow_d.ticks = {shadow_q.ticks[55:0], rx_data};
          if (cnt_q == TICKS_LAST) begin
            state_d = ST_PAYLOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + BYTE_CNT_W'(1);
          end
        end
      end

      ST_PAYLOAD: begin
        if (!line_valid_c) begin
          abort_c = 1'b1;
        end else begin
          crc_en_c        = 1'b1;
          payload_valid_d = 1'b1;
          payload_data_d  = rx_data;
          payload_addr_d  = cnt_q[PAYLOAD_AW-1:0];
          if (cnt_q == PAYLOAD_LAST) begin
            state_d     = ST_FCS;
            cnt_d       = '0;
            fcs_match_d = 1'b1;
          end else begin
            cnt_d = cnt_q + BYTE_CNT_W'(1);
          end
        end
      end

      // CRC engine is idle here, so its register still holds the payload-end value
      ST_FCS: begin
        if (!line_valid_c) begin
          abort_c = 1'b1;
        end else if (cnt_q == FCS_LAST) begin
          state_d      = ST_CHECK;
          cnt_d        = '0;
          frame_done_d = 1'b1;
          frame_ok_d   = fcs_hit_c;
          if (fcs_hit_c) begin
            frame_d = shadow_q;
            good_d  = good_count + 16'd1;
          end else begin
            crc_err_d = crc_err_count + 16'd1;
          end
        end else begin
          fcs_match_d = fcs_hit_c;
          cnt_d       = cnt_q + BYTE_CNT_W'(1);
        end
      end

      // Frame already reported; anything but idle here is overlong tail
      ST_CHECK: begin
        if (line_idle_c) state_d = ST_IDLE;
        else             state_d = ST_DISCARD;
      end

      ST_DISCARD: begin
        if (line_idle_c) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort_c) begin
      state_d = ST_DISCARD;
      drop_d  = drop_count + 16'd1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dest_bc_q     <= 1'b0;
      dest_uc_q     <= 1'b0;
      type_hi_q     <= '0;
      fcs_match_q   <= 1'b0;
      shadow_q      <= '0;
      payload_valid <= 1'b0;
      payload_data  <= '0;
      payload_addr  <= '0;
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      frame_ticks   <= '0;
      frame_src     <= '0;
      good_count    <= '0;
      crc_err_count <= '0;
      drop_count    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dest_bc_q     <= dest_bc_d;
      dest_uc_q     <= dest_uc_d;
      type_hi_q     <= type_hi_d;
      fcs_match_q   <= fcs_match_d;
      shadow_q      <= shadow_d;
      payload_valid <= payload_valid_d;
      payload_data  <= payload_data_d;
      payload_addr  <= payload_addr_d;
      frame_done    <= frame_done_d;
      frame_ok      <= frame_ok_d;
      frame_ticks   <= frame_d.ticks;
      frame_src     <= frame_d.src;
      good_count    <= good_d;
      crc_err_count <= crc_err_d;
      drop_count    <= drop_d;
    end
  end

endmodule
